// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler that shares one multiply_long engine between
// N_REQ requesters. Sequence per operation: IDLE -> GRANT -> START -> BUSY.. -> RESP.
module acc_sched #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned TO_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [$clog2(N_REQ)-1:0]  sel_o,
    output logic [N_REQ-1:0]          done_o,
    output logic [N_REQ-1:0]          err_o,
    output logic                      eng_start_o,
    output logic                      eng_abort_o,
    input  logic                      eng_done_i,
    input  logic [TO_W-1:0]           timeout_cfg_i,
    output logic                      busy_o,
    output logic [TO_W-1:0]           cycle_cnt_o
);

    localparam int unsigned SEL_W = $clog2(N_REQ);

    typedef enum logic [2:0] {StIdle, StGrant, StStart, StBusy, StResp} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] last_owner_q;
    logic [TO_W-1:0]  cnt_q;
    logic [TO_W-1:0]  cnt_inc;
    logic             to_hit;
    logic             win_vld;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] idx;

    // Round-robin search starting just after the previous owner
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = SEL_W'((int'(last_owner_q) + 1 + k) % int'(N_REQ));
            if (!win_vld && req_i[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // BUSY count including the current cycle, saturating; timeout compare on the live limit
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        to_hit  = (timeout_cfg_i != '0) && (cnt_q == timeout_cfg_i - 1'b1);
    end

    // Abort must coincide with the BUSY cycle that times out, so it is decoded from state
    assign eng_abort_o = (state_q == StBusy) && to_hit && !eng_done_i;
    assign busy_o      = (state_q != StIdle);

    // Scheduler FSM with registered grant, select, pulses and result count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gnt_o        <= '0;
            sel_o        <= '0;
            done_o       <= '0;
            err_o        <= '0;
            eng_start_o  <= 1'b0;
            cycle_cnt_o  <= '0;
            cnt_q        <= '0;
            last_owner_q <= SEL_W'(N_REQ - 1);
        end else begin
            eng_start_o <= 1'b0;
            done_o      <= '0;
            err_o       <= '0;
            unique case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        gnt_o   <= N_REQ'(1) << win_idx;
                        sel_o   <= win_idx;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    eng_start_o <= 1'b1;
                    state_q     <= StStart;
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StBusy;
                end
                StBusy: begin
                    cnt_q <= cnt_inc;
                    if (eng_done_i) begin
                        done_o      <= gnt_o;
                        cycle_cnt_o <= cnt_inc;
                        state_q     <= StResp;
                    end else if (to_hit) begin
                        err_o       <= gnt_o;
                        cycle_cnt_o <= cnt_inc;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    gnt_o        <= '0;
                    last_owner_q <= sel_o;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched with N_REQ=2, TO_W=16.
module tb_acc_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [1:0]  gnt_o;
    logic [0:0]  sel_o;
    logic [1:0]  done_o;
    logic [1:0]  err_o;
    logic        eng_start_o;
    logic        eng_abort_o;
    logic        eng_done_i;
    logic [15:0] timeout_cfg_i;
    logic        busy_o;
    logic [15:0] cycle_cnt_o;

    int checks = 0;
    int errors = 0;

    acc_sched #(.N_REQ(2), .TO_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .sel_o         (sel_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .eng_start_o   (eng_start_o),
        .eng_abort_o   (eng_abort_o),
        .eng_done_i    (eng_done_i),
        .timeout_cfg_i (timeout_cfg_i),
        .busy_o        (busy_o),
        .cycle_cnt_o   (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From an IDLE cycle with req_i already driven: run one operation finishing in BUSY cycle n
    task automatic do_op(input logic [1:0] exp_gnt, input int n, input bit drop);
        cyc();
        check("grant", gnt_o, exp_gnt);
        check("sel", sel_o, exp_gnt[1]);
        check("busy_grant", busy_o, 1);
        check("start_in_grant", eng_start_o, 0);
        if (drop) req_i = 2'b00;
        cyc();
        check("start", eng_start_o, 1);
        for (int i = 1; i <= n; i++) begin
            cyc();
            eng_done_i = (i == n);
            #1;
            check("onehot", ($countones(gnt_o) <= 1), 1);
            if (i == n) begin
                check("done_early", done_o, 0);
                check("abort_on_done", eng_abort_o, 0);
            end
        end
        cyc();
        eng_done_i = 1'b0;
        check("done", done_o, exp_gnt);
        check("err_on_done", err_o, 0);
        check("cycle_cnt", cycle_cnt_o, n);
        check("grant_resp", gnt_o, exp_gnt);
        cyc();
        check("busy_idle", busy_o, 0);
        check("grant_idle", gnt_o, 0);
        check("done_gone", done_o, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_i         = 2'b00;
        eng_done_i    = 1'b0;
        timeout_cfg_i = 16'd0;
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt", cycle_cnt_o, 0);
        check("rst_start", eng_start_o, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Single op, engine done noise before BUSY, owner drops request after grant
        req_i      = 2'b01;
        eng_done_i = 1'b1;
        do_op(2'b01, 3, 1'b1);
        check("sel_hold", sel_o, 0);

        // Fresh reset, then two requesters contending for three ops: 0,1,0
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_i = 2'b11;
        do_op(2'b01, 1, 1'b0);
        do_op(2'b10, 2, 1'b0);
        do_op(2'b01, 1, 1'b0);
        req_i = 2'b00;

        // Timeout after 4 BUSY cycles on requester 1
        timeout_cfg_i = 16'd4;
        req_i = 2'b10;
        cyc();
        check("to_grant", gnt_o, 2'b10);
        cyc();
        cyc();
        cyc();
        cyc();
        check("abort_early", eng_abort_o, 0);
        cyc();
        check("abort", eng_abort_o, 1);
        check("err_early", err_o, 0);
        cyc();
        req_i = 2'b00;
        check("err", err_o, 2'b10);
        check("done_on_to", done_o, 0);
        check("to_cycle_cnt", cycle_cnt_o, 4);
        check("abort_gone", eng_abort_o, 0);
        cyc();
        check("to_idle", busy_o, 0);
        check("err_gone", err_o, 0);

        // Done lands exactly on the timeout cycle: done wins
        req_i = 2'b01;
        do_op(2'b01, 4, 1'b0);
        req_i = 2'b00;
        timeout_cfg_i = 16'd0;

        // Reset in BUSY abandons the op
        req_i = 2'b01;
        cyc();
        cyc();
        cyc();
        cyc();
        check("pre_rst_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", gnt_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_cnt", cycle_cnt_o, 0);
        check("mid_rst_abort", eng_abort_o, 0);
        req_i = 2'b11;
        cyc();
        check("in_rst_done", done_o, 0);
        check("in_rst_err", err_o, 0);
        rst_n = 1'b1;
        check("post_rst_gnt", gnt_o, 0);
        do_op(2'b01, 1, 1'b0);
        req_i = 2'b00;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
